// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 definitions for the streaming encryption engine:
//   - NR          : number of AES-128 rounds
//   - fsm_state_e : engine FSM states (IDLE / RUN / DONE)
//   - SBOX/sbox   : forward S-box lookup
//   - rcon        : key-schedule round constant table, indexed by round 1..10
//   - xtime, mix_column, sub_word : GF(2^8) and word helpers
// Byte order follows FIPS-197: bit 127 of a 128-bit block is byte 0, and
// bytes are stored column-major (byte 4*c + r is row r of column c).
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX[a];
    endfunction

    // Round constants; entry 0 and 11..15 are never used by a real round.
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column: {a0,a1,a2,a3} with a0 in the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

// File: rtl/aes_round.sv
// ---------------------------------------------------------------------------
// aes_round
// One combinational AES-128 encryption round plus the matching key-schedule
// step, so rounds can be chained without a pre-expanded key.
// Ports:
//   state_i [127:0] : state entering the round
//   rkey_i  [127:0] : round key used by the previous round (master key for round 1)
//   rcon_i  [7:0]   : round constant for this round
//   last_i          : final round, MixColumns is skipped
//   state_o [127:0] : state after SubBytes/ShiftRows/MixColumns/AddRoundKey
//   rkey_o  [127:0] : round key used by this round (feeds the next round)
// ---------------------------------------------------------------------------
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic [7:0]   rcon_i,
    input  logic         last_i,
    output logic [127:0] state_o,
    output logic [127:0] rkey_o
);

    logic [31:0]  kw_temp;
    logic [31:0]  kw0, kw1, kw2, kw3;
    logic [127:0] next_key;
    logic [127:0] sb_state;
    logic [127:0] sr_state;
    logic [127:0] mc_state;

    // Key schedule: derive the four words of the next round key from the
    // previous key's last word (RotWord, SubWord, Rcon) and a running XOR.
    always_comb begin
        kw_temp  = sub_word({rkey_i[23:0], rkey_i[31:24]}) ^ {rcon_i, 24'h000000};
        kw0      = rkey_i[127:96] ^ kw_temp;
        kw1      = rkey_i[95:64]  ^ kw0;
        kw2      = rkey_i[63:32]  ^ kw1;
        kw3      = rkey_i[31:0]   ^ kw2;
        next_key = {kw0, kw1, kw2, kw3};
    end

    // Round datapath. ShiftRows moves row r left by r columns, so output
    // byte (col c, row r) comes from input column (c + r) mod 4.
    always_comb begin
        sb_state = '0;
        sr_state = '0;
        mc_state = '0;
        for (int i = 0; i < 16; i++) begin
            sb_state[8*i +: 8] = sbox(state_i[8*i +: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_state[127 - 8*(4*c + r) -: 8] = sb_state[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc_state[127 - 32*c -: 32] = mix_column(sr_state[127 - 32*c -: 32]);
        end
        state_o = (last_i ? sr_state : mc_state) ^ next_key;
        rkey_o  = next_key;
    end

endmodule

// File: rtl/aes_enc_stream.sv
// ---------------------------------------------------------------------------
// aes_enc_stream
// Handshaked AES-128 encryption engine with on-the-fly key schedule.
// A master key (and, in CTR mode, an initial counter) is loaded once; blocks
// are then streamed through with valid/ready handshakes, one at a time.
// Parameters:
//   UNROLL   : rounds per clock, 1, 2, 5 or 10
//   CTR_MODE : 0 = ECB (encrypt in_data), 1 = CTR (encrypt counter, XOR in_data)
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   key_valid/key_ready/key_in/iv_in : key and initial-counter load
//   in_valid/in_ready/in_data      : plaintext input stream
//   out_valid/out_ready/out_data   : ciphertext output stream
// ---------------------------------------------------------------------------
module aes_enc_stream
    import aes_pkg::*;
#(
    parameter int UNROLL   = 1,
    parameter int CTR_MODE = 0
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    input  logic [127:0] iv_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
        $error("aes_enc_stream: UNROLL must be 1, 2, 5 or 10");
    end

    fsm_state_e   fsm_q, fsm_d;
    logic         key_loaded_q, key_loaded_d;
    logic [127:0] mkey_q, mkey_d;
    logic [127:0] ctr_q, ctr_d;
    logic [127:0] pt_q, pt_d;
    logic [127:0] blk_q, blk_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] out_data_q, out_data_d;
    logic [3:0]   rnd_after;

    logic [UNROLL:0][127:0] chain_state;
    logic [UNROLL:0][127:0] chain_key;

    assign chain_state[0] = blk_q;
    assign chain_key[0]   = rkey_q;

    // UNROLL rounds are chained per clock; each stage knows its absolute
    // round number so it picks the right Rcon and skips MixColumns on round NR.
    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        logic [3:0] round_num;
        assign round_num = rnd_q + 4'(g + 1);
        aes_round u_round (
            .state_i (chain_state[g]),
            .rkey_i  (chain_key[g]),
            .rcon_i  (rcon(round_num)),
            .last_i  (round_num == 4'(NR)),
            .state_o (chain_state[g+1]),
            .rkey_o  (chain_key[g+1])
        );
    end

    // A pending key load takes priority over a block, so in_ready drops
    // while key_valid is high; the block is taken the cycle after the load.
    assign key_ready = (fsm_q == ST_IDLE);
    assign in_ready  = (fsm_q == ST_IDLE) && key_loaded_q && !key_valid;
    assign out_valid = (fsm_q == ST_DONE);
    assign out_data  = out_data_q;
    assign rnd_after = rnd_q + 4'(UNROLL);

    always_comb begin
        fsm_d        = fsm_q;
        key_loaded_d = key_loaded_q;
        mkey_d       = mkey_q;
        ctr_d        = ctr_q;
        pt_d         = pt_q;
        blk_d        = blk_q;
        rkey_d       = rkey_q;
        rnd_d        = rnd_q;
        out_data_d   = out_data_q;
        unique case (fsm_q)
            ST_IDLE: begin
                if (key_valid) begin
                    mkey_d       = key_in;
                    key_loaded_d = 1'b1;
                    if (CTR_MODE != 0) begin
                        ctr_d = iv_in;
                    end
                end else if (in_valid && key_loaded_q) begin
                    pt_d   = in_data;
                    blk_d  = ((CTR_MODE != 0) ? ctr_q : in_data) ^ mkey_q;
                    rkey_d = mkey_q;
                    rnd_d  = 4'd0;
                    fsm_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                blk_d  = chain_state[UNROLL];
                rkey_d = chain_key[UNROLL];
                rnd_d  = rnd_after;
                if (rnd_after == 4'(NR)) begin
                    out_data_d = (CTR_MODE != 0) ? (chain_state[UNROLL] ^ pt_q) : chain_state[UNROLL];
                    fsm_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                // Only the low counter word advances; it wraps without carry.
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                    if (CTR_MODE != 0) begin
                        ctr_d[31:0] = ctr_q[31:0] + 32'd1;
                    end
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= ST_IDLE;
            key_loaded_q <= 1'b0;
            mkey_q       <= '0;
            ctr_q        <= '0;
            pt_q         <= '0;
            blk_q        <= '0;
            rkey_q       <= '0;
            rnd_q        <= '0;
            out_data_q   <= '0;
        end else begin
            fsm_q        <= fsm_d;
            key_loaded_q <= key_loaded_d;
            mkey_q       <= mkey_d;
            ctr_q        <= ctr_d;
            pt_q         <= pt_d;
            blk_q        <= blk_d;
            rkey_q       <= rkey_d;
            rnd_q        <= rnd_d;
            out_data_q   <= out_data_d;
        end
    end

endmodule

// File: tb/tb_aes_enc_stream.sv
// ---------------------------------------------------------------------------
// tb_aes_enc_stream
// Self-checking bench for aes_enc_stream. Instances:
//   dut_a   : ECB, UNROLL=1 (handshake, backpressure, key and reset cases)
//   dut_b*  : ECB, UNROLL=2/5/10 sharing one stimulus set (latency per build)
//   dut_c   : CTR, UNROLL=2
// Expected ciphertexts come from a byte-level AES-128 model whose S-box is
// derived from the GF(2^8) inverse and affine map at time zero.
// ---------------------------------------------------------------------------
module tb_aes_enc_stream;

    logic clk;
    logic rst;

    logic         a_key_valid, a_key_ready, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0] a_key_in, a_iv_in, a_in_data, a_out_data;

    logic         b_key_valid, b_in_valid, b_out_ready;
    logic [127:0] b_key_in, b_iv_in, b_in_data;
    logic         b2_key_ready, b2_in_ready, b2_out_valid;
    logic         b5_key_ready, b5_in_ready, b5_out_valid;
    logic         b10_key_ready, b10_in_ready, b10_out_valid;
    logic [127:0] b2_out_data, b5_out_data, b10_out_data;

    logic         c_key_valid, c_key_ready, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [127:0] c_key_in, c_iv_in, c_in_data, c_out_data;

    int checks = 0;
    int passes = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] a_key_cur;

    aes_enc_stream #(.UNROLL(1), .CTR_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .key_valid(a_key_valid), .key_ready(a_key_ready), .key_in(a_key_in),
        .iv_in(a_iv_in), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data));

    aes_enc_stream #(.UNROLL(2), .CTR_MODE(0)) dut_b2 (
        .clk(clk), .rst(rst), .key_valid(b_key_valid), .key_ready(b2_key_ready), .key_in(b_key_in),
        .iv_in(b_iv_in), .in_valid(b_in_valid), .in_ready(b2_in_ready), .in_data(b_in_data),
        .out_valid(b2_out_valid), .out_ready(b_out_ready), .out_data(b2_out_data));

    aes_enc_stream #(.UNROLL(5), .CTR_MODE(0)) dut_b5 (
        .clk(clk), .rst(rst), .key_valid(b_key_valid), .key_ready(b5_key_ready), .key_in(b_key_in),
        .iv_in(b_iv_in), .in_valid(b_in_valid), .in_ready(b5_in_ready), .in_data(b_in_data),
        .out_valid(b5_out_valid), .out_ready(b_out_ready), .out_data(b5_out_data));

    aes_enc_stream #(.UNROLL(10), .CTR_MODE(0)) dut_b10 (
        .clk(clk), .rst(rst), .key_valid(b_key_valid), .key_ready(b10_key_ready), .key_in(b_key_in),
        .iv_in(b_iv_in), .in_valid(b_in_valid), .in_ready(b10_in_ready), .in_data(b_in_data),
        .out_valid(b10_out_valid), .out_ready(b_out_ready), .out_data(b10_out_data));

    aes_enc_stream #(.UNROLL(2), .CTR_MODE(1)) dut_c (
        .clk(clk), .rst(rst), .key_valid(c_key_valid), .key_ready(c_key_ready), .key_in(c_key_in),
        .iv_in(c_iv_in), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic init_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]], sbox_m[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c + r] = t[4*((c + r) % 4) + r];
            if (rnd < 10) begin
                for (int i = 0; i < 16; i++) t[i] = s[i];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        s[4*c + r] = gmul(8'h02, t[4*c + r]) ^ gmul(8'h03, t[4*c + (r+1)%4])
                                   ^ t[4*c + (r+2)%4] ^ t[4*c + (r+3)%4];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_load_key(input logic [127:0] k, output bit ok);
        a_key_in    = k;
        a_key_valid = 1'b1;
        #1;
        for (int i = 0; i < 50 && !a_key_ready; i++) tick();
        ok = a_key_ready;
        tick();
        a_key_valid = 1'b0;
        if (ok) a_key_cur = k;
    endtask

    // Offers one block, then counts cycles from the accept until out_valid.
    task automatic a_send(input logic [127:0] d, output int lat, output logic [127:0] res);
        int n;
        a_in_data  = d;
        a_in_valid = 1'b1;
        #1;
        for (int i = 0; i < 50 && !a_in_ready; i++) tick();
        if (!a_in_ready) begin
            a_in_valid = 1'b0;
            lat = -1;
            res = '0;
            return;
        end
        tick();
        a_in_valid = 1'b0;
        n = 1;
        while (!a_out_valid && n < 40) begin
            tick();
            n++;
        end
        lat = a_out_valid ? n : -1;
        res = a_out_data;
    endtask

    task automatic c_load_key(input logic [127:0] k, input logic [127:0] iv, output bit ok);
        c_key_in    = k;
        c_iv_in     = iv;
        c_key_valid = 1'b1;
        #1;
        for (int i = 0; i < 50 && !c_key_ready; i++) tick();
        ok = c_key_ready;
        tick();
        c_key_valid = 1'b0;
    endtask

    task automatic c_send(input logic [127:0] d, output int lat, output logic [127:0] res);
        int n;
        c_in_data  = d;
        c_in_valid = 1'b1;
        #1;
        for (int i = 0; i < 50 && !c_in_ready; i++) tick();
        if (!c_in_ready) begin
            c_in_valid = 1'b0;
            lat = -1;
            res = '0;
            return;
        end
        tick();
        c_in_valid = 1'b0;
        n = 1;
        while (!c_out_valid && n < 40) begin
            tick();
            n++;
        end
        lat = c_out_valid ? n : -1;
        res = c_out_data;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({a_key_ready, a_in_ready, a_out_valid} !== 3'b100)
            $display("[TB] FAIL reset_flags: got kr/ir/ov=%b required 100", {a_key_ready, a_in_ready, a_out_valid});
        else passes++;
        checks++;
        if (a_out_data !== 128'h0) $display("[TB] FAIL reset_out_data: got %h required 0", a_out_data);
        else passes++;
        checks++;
        if ({c_key_ready, c_in_ready, c_out_valid, b10_out_valid} !== 4'b1000)
            $display("[TB] FAIL reset_other: got %b required 1000", {c_key_ready, c_in_ready, c_out_valid, b10_out_valid});
        else passes++;
    endtask

    task automatic test_no_key();
        int bad;
        bad = 0;
        a_in_data  = rand128();
        a_in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0 || a_key_ready !== 1'b1) bad++;
            tick();
        end
        a_in_valid = 1'b0;
        checks++;
        if (bad !== 0) $display("[TB] FAIL no_key_accept: got %0d bad cycles required 0", bad);
        else passes++;
    endtask

    task automatic test_fips_vector();
        bit ok;
        int lat;
        logic [127:0] res;
        a_out_ready = 1'b1;
        a_load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, ok);
        checks++;
        if (!ok) $display("[TB] FAIL fips_key_load: got key_ready=0 required 1");
        else passes++;
        a_send(128'h3243f6a8885a308d313198a2e0370734, lat, res);
        checks++;
        if (res !== 128'h3925841d02dc09fbdc118597196a0b32)
            $display("[TB] FAIL fips_data: got %h required 3925841d02dc09fbdc118597196a0b32", res);
        else passes++;
        checks++;
        if (lat !== 11) $display("[TB] FAIL fips_latency: got %0d required 11", lat);
        else passes++;
    endtask

    task automatic test_random_ecb();
        bit ok;
        int lat;
        logic [127:0] pt, res, exp;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || $urandom_range(0, 1) == 1) a_load_key(rand128(), ok);
            pt  = rand128();
            exp = ref_encrypt(a_key_cur, pt);
            a_send(pt, lat, res);
            checks++;
            if (res !== exp || lat !== 11)
                $display("[TB] FAIL ecb_random[%0d]: got %h lat %0d required %h lat 11", i, res, lat, exp);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [127:0] pt, res, exp;
        tick();
        a_out_ready = 1'b0;
        pt  = rand128();
        exp = ref_encrypt(a_key_cur, pt);
        a_send(pt, lat, res);
        checks++;
        if (res !== exp) $display("[TB] FAIL bp_data: got %h required %h", res, exp);
        else passes++;
        bad = 0;
        a_in_valid = 1'b1;
        a_in_data  = rand128();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (a_out_data !== exp || {a_out_valid, a_in_ready, a_key_ready} !== 3'b100) bad++;
        end
        a_in_valid = 1'b0;
        checks++;
        if (bad !== 0) $display("[TB] FAIL bp_hold: got %0d unstable cycles required 0", bad);
        else passes++;
        a_out_ready = 1'b1;
        tick();
        checks++;
        if ({a_out_valid, a_key_ready, a_in_ready} !== 3'b011)
            $display("[TB] FAIL bp_release: got ov/kr/ir=%b required 011", {a_out_valid, a_key_ready, a_in_ready});
        else passes++;
    endtask

    task automatic test_key_during_run();
        int n;
        int bad;
        int lat;
        logic [127:0] pt, res, exp;
        pt  = rand128();
        exp = ref_encrypt(a_key_cur, pt);
        a_in_data  = pt;
        a_in_valid = 1'b1;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) $display("[TB] FAIL kdr_accept: got in_ready=%b required 1", a_in_ready);
        else passes++;
        tick();
        a_in_valid  = 1'b0;
        a_key_in    = rand128();
        a_key_valid = 1'b1;
        bad = 0;
        n = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (a_key_ready !== 1'b0) bad++;
            tick();
            n++;
        end
        a_key_valid = 1'b0;
        checks++;
        if (bad !== 0) $display("[TB] FAIL kdr_key_ready: got %0d cycles high required 0", bad);
        else passes++;
        while (!a_out_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (a_out_data !== exp || n !== 11)
            $display("[TB] FAIL kdr_data: got %h at cycle %0d required %h at 11", a_out_data, n, exp);
        else passes++;
        pt  = rand128();
        exp = ref_encrypt(a_key_cur, pt);
        a_send(pt, lat, res);
        checks++;
        if (res !== exp) $display("[TB] FAIL kdr_key_kept: got %h required %h", res, exp);
        else passes++;
    endtask

    task automatic test_key_priority();
        int n;
        logic [127:0] k, pt, exp;
        tick();
        k   = rand128();
        pt  = rand128();
        exp = ref_encrypt(k, pt);
        a_key_in    = k;
        a_key_valid = 1'b1;
        a_in_data   = pt;
        a_in_valid  = 1'b1;
        #1;
        checks++;
        if ({a_key_ready, a_in_ready} !== 2'b10)
            $display("[TB] FAIL prio_ready: got kr/ir=%b required 10", {a_key_ready, a_in_ready});
        else passes++;
        tick();
        a_key_valid = 1'b0;
        a_key_cur   = k;
        #1;
        checks++;
        if (a_in_ready !== 1'b1) $display("[TB] FAIL prio_block_wait: got in_ready=%b required 1", a_in_ready);
        else passes++;
        tick();
        a_in_valid = 1'b0;
        n = 1;
        while (!a_out_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (a_out_data !== exp || n !== 11)
            $display("[TB] FAIL prio_new_key: got %h at cycle %0d required %h at 11", a_out_data, n, exp);
        else passes++;
    endtask

    task automatic test_unroll();
        int n;
        int lat2, lat5, lat10;
        logic [127:0] r2, r5, r10, k, pt, exp;
        b_out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            k  = (v == 0) ? 128'h000102030405060708090a0b0c0d0e0f : rand128();
            pt = (v == 0) ? 128'h00112233445566778899aabbccddeeff : rand128();
            exp = (v == 0) ? 128'h69c4e0d86a7b0430d8cdb78070b4c55a : ref_encrypt(k, pt);
            b_key_in    = k;
            b_key_valid = 1'b1;
            tick();
            b_key_valid = 1'b0;
            b_in_data   = pt;
            b_in_valid  = 1'b1;
            #1;
            checks++;
            if ({b2_in_ready, b5_in_ready, b10_in_ready} !== 3'b111)
                $display("[TB] FAIL unroll_in_ready[%0d]: got %b required 111", v, {b2_in_ready, b5_in_ready, b10_in_ready});
            else passes++;
            tick();
            b_in_valid = 1'b0;
            lat2 = -1; lat5 = -1; lat10 = -1;
            r2 = '0; r5 = '0; r10 = '0;
            for (n = 1; n < 16; n++) begin
                if (b2_out_valid && lat2 < 0) begin lat2 = n; r2 = b2_out_data; end
                if (b5_out_valid && lat5 < 0) begin lat5 = n; r5 = b5_out_data; end
                if (b10_out_valid && lat10 < 0) begin lat10 = n; r10 = b10_out_data; end
                tick();
            end
            checks++;
            if (lat2 !== 6 || lat5 !== 3 || lat10 !== 2)
                $display("[TB] FAIL unroll_latency[%0d]: got %0d/%0d/%0d required 6/3/2", v, lat2, lat5, lat10);
            else passes++;
            checks++;
            if (r2 !== exp || r5 !== exp || r10 !== exp)
                $display("[TB] FAIL unroll_data[%0d]: got %h %h %h required %h", v, r2, r5, r10, exp);
            else passes++;
            checks++;
            if ({b2_key_ready, b5_key_ready, b10_key_ready} !== 3'b111)
                $display("[TB] FAIL unroll_idle[%0d]: got %b required 111", v, {b2_key_ready, b5_key_ready, b10_key_ready});
            else passes++;
        end
    endtask

    task automatic test_ctr();
        bit ok;
        int lat;
        logic [127:0] k, iv, ctr, p1, p2, p3, res, exp;
        c_out_ready = 1'b1;
        c_load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, ok);
        c_send(128'h6bc1bee22e409f96e93d7e117393172a, lat, res);
        checks++;
        if (res !== 128'h874d6191b620e3261bef6864990db6ce || lat !== 6)
            $display("[TB] FAIL ctr_block1: got %h lat %0d required 874d6191b620e3261bef6864990db6ce lat 6", res, lat);
        else passes++;
        c_send(128'hae2d8a571e03ac9c9eb76fac45af8e51, lat, res);
        checks++;
        if (res !== 128'h9806f66b7970fdff8617187bb9fffdff)
            $display("[TB] FAIL ctr_block2: got %h required 9806f66b7970fdff8617187bb9fffdff", res);
        else passes++;
        // Counter wrap: low word all ones, upper 96 bits must pass through.
        k  = rand128();
        iv = {$urandom, $urandom, $urandom, 32'hffffffff};
        c_load_key(k, iv, ok);
        checks++;
        if (!ok) $display("[TB] FAIL ctr_key_load: got key_ready=0 required 1");
        else passes++;
        p1 = rand128();
        p2 = rand128();
        p3 = rand128();
        ctr = iv;
        exp = ref_encrypt(k, ctr) ^ p1;
        c_send(p1, lat, res);
        checks++;
        if (res !== exp) $display("[TB] FAIL ctr_wrap_first: got %h required %h", res, exp);
        else passes++;
        ctr = {iv[127:32], 32'h00000000};
        exp = ref_encrypt(k, ctr) ^ p2;
        c_send(p2, lat, res);
        checks++;
        if (res !== exp) $display("[TB] FAIL ctr_wrap_second: got %h required %h", res, exp);
        else passes++;
        ctr = {iv[127:32], 32'h00000001};
        exp = ref_encrypt(k, ctr) ^ p3;
        c_send(p3, lat, res);
        checks++;
        if (res !== exp) $display("[TB] FAIL ctr_wrap_third: got %h required %h", res, exp);
        else passes++;
    endtask

    task automatic test_reset_mid_run();
        int bad;
        int lat;
        bit ok;
        logic [127:0] pt, res, exp;
        tick();
        a_in_data  = rand128();
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            #1;
            if ({a_out_valid, a_in_ready, a_key_ready} !== 3'b001) bad++;
            tick();
        end
        a_in_valid = 1'b0;
        checks++;
        if (bad !== 0) $display("[TB] FAIL rst_mid_run: got %0d bad cycles required 0", bad);
        else passes++;
        a_load_key(rand128(), ok);
        pt  = rand128();
        exp = ref_encrypt(a_key_cur, pt);
        a_send(pt, lat, res);
        checks++;
        if (res !== exp || lat !== 11)
            $display("[TB] FAIL rst_recover: got %h lat %0d required %h lat 11", res, lat, exp);
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        a_key_valid = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        a_key_in = '0; a_iv_in = '0; a_in_data = '0; a_key_cur = '0;
        b_key_valid = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        b_key_in = '0; b_iv_in = '0; b_in_data = '0;
        c_key_valid = 1'b0; c_in_valid = 1'b0; c_out_ready = 1'b1;
        c_key_in = '0; c_iv_in = '0; c_in_data = '0;
        init_sbox();
        $display("[TB] starting aes_enc_stream bench");
        test_reset();
        test_no_key();
        test_fips_vector();
        test_random_ecb();
        test_backpressure();
        test_key_during_run();
        test_key_priority();
        test_unroll();
        test_ctr();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/aes_enc_stream.md
Name: aes_enc_stream

Overview:
- Parametrised, handshaked AES-128 encryption engine; successor to the fixed, free-running encrypt top.
- Master key and IV are loaded once. Blocks are then streamed in and out with valid/ready handshakes.
- The key schedule is computed on the fly, so no 1408-bit expanded-key bus is needed.
- Rounds per cycle (UNROLL) and an optional CTR mode are selectable, so one block serves the area-lean and throughput builds.

Parameters:
- UNROLL, 1, AES rounds applied per clock; legal values 1, 2, 5, 10. Any other value is an elaboration error.
- CTR_MODE, 0, 0 = ECB (encrypt in_data); 1 = CTR (encrypt counter, XOR with in_data).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  key/IV load request
- key_ready  out  1  high when the engine can accept a key (IDLE)
- key_in  in  128  master key; bit 127 = byte 0 (FIPS-197 order)
- iv_in  in  128  initial counter, sampled with key_in; ignored when CTR_MODE=0
- in_valid  in  1  plaintext block valid
- in_ready  out  1  engine accepts a block this cycle
- in_data  in  128  plaintext block
- out_valid  out  1  ciphertext valid
- out_ready  in  1  downstream accepts the ciphertext
- out_data  out  128  ciphertext block

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, key_loaded=0, out_valid=0, out_data=0, counter=0. key_ready=1 and in_ready=0 in the cycle after reset.
- Asserting rst mid-operation aborts the block in flight; no output is produced.
- FSM has three states:
  - IDLE: key_ready=1; in_ready=key_loaded.
  - RUN: rounds executing; key_ready=0; in_ready=0.
  - DONE: out_valid=1; key_ready=0; in_ready=0.
- Key load: key_valid&&key_ready (IDLE only) latches master key, sets key_loaded=1, and in CTR mode latches counter=iv_in. Stays in IDLE.
- Block accept: in IDLE, in_valid&&in_ready latches in_data into the pt register and loads state=src^master_key.
  - src = in_data for ECB, counter for CTR.
  - Round-key register is loaded with master_key; round counter rnd=0; next state RUN.
- RUN: each edge applies UNROLL rounds, each round being SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - The next round key is derived combinationally from the current one, using an Rcon indexed by the round number.
  - Round 10 omits MixColumns.
  - After the edge on which rnd reaches 10: out_data = state (ECB) or state^pt (CTR); next state DONE.
- Latency: accept cycle T, then out_valid asserted in cycle T+10/UNROLL+1 (UNROLL=1 gives 11; UNROLL=10 gives 2).
- DONE:
  - out_data and out_valid are held stable while out_ready=0.
  - When out_valid&&out_ready: go to IDLE. In CTR mode, counter[31:0] increments mod 2^32; bits [127:32] are unchanged (0xFFFFFFFF wraps to 0, no carry).
- No overlap: the next block is accepted no earlier than the cycle after the output handshake. Throughput is one block per 10/UNROLL+2 cycles.
- key_valid asserted outside IDLE: not accepted; the requester holds it until key_ready.
- in_valid before any key is loaded: in_ready=0, nothing accepted.
- key_valid and in_valid both high in IDLE with key_loaded=1: the key load wins; the block waits one cycle and is then accepted under the new key.
- The round key is regenerated from master_key on every block; the master key persists across blocks until reloaded or rst.

Decomposition:
- Shared package aes_pkg contains:
  - the S-box function/ROM;
  - the Rcon constant table;
  - xtime/MixColumns helper functions;
  - the round-count constant NR=10;
  - the FSM state enum.
- One sub-module, aes_round: combinational.
  - Inputs: state, round key, rcon, last-round flag.
  - Outputs: next state, next round key.
  - The top instantiates UNROLL copies in a chain.

Test Plan:
- ECB, UNROLL=1, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> out_data 3925841d02dc09fbdc118597196a0b32; out_valid exactly 11 cycles after accept.
- ECB, UNROLL=1,2,5,10, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a with latencies 11/6/3/2.
- CTR_MODE=1, key 2b7e151628aed2a6abf7158809cf4f3c, iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, blocks 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51 -> 874d6191b620e3261bef6864990db6ce then 9806f66b7970fdff8617187bb9fffdff.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_data stable, in_ready=0, key_ready=0. Raise out_ready -> one handshake, IDLE next cycle.
- Boundaries:
  - in_valid with no key loaded -> never accepted.
  - key_valid during RUN -> key_ready=0 and the key is ignored.
  - CTR iv ...ffffffff -> second counter ...00000000 with upper 96 bits unchanged.
- Reset mid-RUN (cycle 5 of 11) -> out_valid never asserts; key_loaded=0; in_ready=0 until a new key is loaded.
